mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares one single-port 256x16 synchronous data/instruction memory among up to NREQ requesters: the pipelined CPU's instruction-fetch port, its data port, and a host loader/debug port. It sits between the CPU memory ports and the memory macro. It issues at most one memory command per cycle and returns read data with fixed one-cycle latency. A lock mode gives the host exclusive ownership for program download or inspection while the CPU is idle.

## Interface
Parameters:
- NREQ, 3, number of requesters (0 = CPU data, 1 = CPU fetch, 2 = host)
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- LOCK_ID, 2, requester index that may hold the lock

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- req  in  NREQ  request per requester; held with addr/we/wdata stable until gnt
- we  in  NREQ  1 = write, 0 = read, per requester
- addr  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- wdata  in  NREQ*DATA_W  packed write data, same packing as addr
- lock_req  in  1  host request for exclusive ownership
- gnt  out  NREQ  one-hot, combinational; command accepted this cycle
- rvalid  out  NREQ  one-hot, registered; rdata is valid for that requester
- rdata  out  DATA_W  read data, shared by all requesters
- locked  out  1  high while the lock is held
- mem_en, mem_we  out  1 each  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Eligible set: in state ARB, every i with req[i]=1. In state LOCKED, only LOCK_ID.
- Winner: the first eligible index found searching upward from ptr, wrapping modulo NREQ. gnt[winner]=1. No winner when the eligible set is empty.
- On a grant: ptr <= (winner+1) mod NREQ. Otherwise ptr holds. Reset value of ptr is 0.
- Memory drive when a winner exists: mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w].
- Memory drive with no winner: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read: a grant with we=0 sets rvalid[w]=1 on the next cycle. rdata=mem_rdata when any rvalid is set, else 0.
- Write: no rvalid is produced.
- FSM with two states, ARB and LOCKED:
  - ARB -> LOCKED when lock_req=1 at the edge. Arbitration in the cycle lock_req rises is still normal.
  - LOCKED -> ARB when lock_req=0 at the edge. On this transition ptr <= (LOCK_ID+1) mod NREQ so the other requesters are served first.
  - locked = (state == LOCKED).
- A requester that keeps req high after gnt is treated as issuing a new request and re-enters arbitration that same cycle. Back-to-back grants to one requester occur only when it is the sole eligible requester.
- Simultaneous read grant and lock entry: the rvalid is still delivered.

## Timing
- Grant latency: 0 cycles (gnt is in the same cycle as req) when the requester is the winner.
- Worst-case wait in ARB: NREQ-1 cycles.
- Read latency: rvalid and rdata appear exactly 1 cycle after gnt. Throughput is one command per cycle.
- Lock entry and exit take effect on the cycle after the lock_req edge is sampled.
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, locked=0, state=ARB, ptr=0.
- Reset asserted mid-operation: any pending rvalid is discarded, the lock is released, and the command in flight is lost. Requesters must re-issue after reset.
- Requests from non-lock requesters are ignored while LOCKED. Their req stays high with no gnt, and no error is flagged.

## Structure
- Package mem_arb_pkg holds:
  - the state enum {ARB, LOCKED}
  - requester index constants REQ_DATA=0, REQ_FETCH=1, REQ_HOST=2
  - default widths ADDR_W=8 and DATA_W=16
- Sub-module rr_picker: purely combinational. Inputs are the eligible vector and ptr; outputs are the one-hot winner and its index. This is the only natural split.
- The top level holds the FSM, the ptr register, the rvalid register and the memory output muxes.

## Test plan
- Single read: req=3'b001, addr0=8'h10, mem holds 16'hBEEF -> gnt=3'b001 in the same cycle, mem_addr=8'h10; next cycle rvalid=3'b001, rdata=16'hBEEF.
- Contention: req=3'b111 held with ptr=0 -> gnt sequence 001, 010, 100, 001 on consecutive cycles; ptr follows 1, 2, 0, 1.
- Write: req=3'b100, we=3'b100, addr2=8'h3F, wdata2=16'h1234 -> mem_en=1, mem_we=1, mem_addr=8'h3F, mem_wdata=16'h1234; rvalid stays 0; a subsequent read of 8'h3F returns 16'h1234.
- Lock: lock_req=1 with req=3'b111 -> next cycle locked=1 and only gnt=3'b100 is issued for 5 cycles. Drop lock_req -> locked=0 next cycle, and the first grant after that is 3'b001.
- Idle: req=0 -> mem_en=0, mem_addr=0, gnt=0, ptr unchanged.
- Reset mid-read: grant a read, then pull reset low before the next edge -> rvalid=0, locked=0, ptr=0 immediately, with no rdata delivered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

    // Arbiter operating mode.
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester slots on the shared memory.
    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_HOST  = 2;

    // Default geometry of the 256x16 memory macro.
    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 16;

    // Index width for a requester count; at least one bit so a single requester still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  eligible_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Walk NREQ candidates starting at ptr; the first hit wins and masks all later ones.
    always_comb begin
        int  cand;
        logic hit;
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        hit      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            cand = (cand >= NREQ) ? (cand - NREQ) : cand;
            hit  = !valid_o && eligible_i[cand];
            onehot_o[cand] = onehot_o[cand] | hit;
            idx_o   = hit ? IDX_W'(cand) : idx_o;
            valid_o = valid_o | hit;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// CPU data port, CPU fetch port and host port, with a host lock mode.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int LOCK_ID = REQ_HOST
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    input  logic                   lock_req,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   locked,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int IDX_W = idx_width(NREQ);
    localparam logic [NREQ-1:0]  LOCK_MASK     = {{(NREQ-1){1'b0}}, 1'b1} << LOCK_ID;
    localparam logic [IDX_W-1:0] LOCK_EXIT_PTR = IDX_W'((LOCK_ID + 1) % NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  rvalid_q, rvalid_d;

    logic [NREQ-1:0]  eligible_s;
    logic [NREQ-1:0]  win_onehot_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_valid_s;

    // In LOCKED only the lock holder may compete; everyone else waits silently.
    always_comb begin
        eligible_s = '0;
        case (state_q)
            ARB:     eligible_s = req;
            LOCKED:  eligible_s = req & LOCK_MASK;
            default: eligible_s = '0;
        endcase
    end

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible_i (eligible_s),
        .ptr_i      (ptr_q),
        .onehot_o   (win_onehot_s),
        .idx_o      (win_idx_s),
        .valid_o    (win_valid_s)
    );

    // Mode register: async reset back to ARB.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode transitions follow the sampled lock_req level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     state_d = lock_req ? LOCKED : ARB;
            LOCKED:  state_d = lock_req ? LOCKED : ARB;
            default: state_d = ARB;
        endcase
    end

    // Pointer and read-valid next state; lock exit hands priority to the requester after the host.
    always_comb begin
        ptr_d    = ptr_q;
        rvalid_d = '0;
        if ((state_q == LOCKED) && !lock_req) begin
            ptr_d = LOCK_EXIT_PTR;
        end else if (win_valid_s) begin
            ptr_d = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + IDX_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
        if (win_valid_s && !we[win_idx_s]) begin
            rvalid_d = win_onehot_s;
        end else begin
            rvalid_d = '0;
        end
    end

    // Pointer and read-valid registers; reset discards any read still in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Grant, memory command mux and read-return outputs.
    always_comb begin
        gnt       = win_onehot_s;
        locked    = (state_q == LOCKED);
        rvalid    = rvalid_q;
        mem_en    = win_valid_s;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (win_valid_s) begin
            mem_we    = we[win_idx_s];
            mem_addr  = addr[win_idx_s*ADDR_W +: ADDR_W];
            mem_wdata = wdata[win_idx_s*DATA_W +: DATA_W];
        end else begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
        if (|rvalid_q) begin
            rdata = mem_rdata;
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 synchronous memory.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [23:0] addr;
    logic [47:0] wdata;
    logic        lock_req;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic        locked;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int total;
    int bad;

    logic [15:0] mem [0:255];

    mem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .lock_req  (lock_req),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .locked    (locked),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory macro model: one-cycle synchronous read, write on strobe.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic test_reset();
        reset = 1'b0; req = 3'b000; we = 3'b000; lock_req = 1'b0;
        addr = {8'h30, 8'h20, 8'h10}; wdata = 48'h0;
        #2;
        total++; if (gnt !== 3'b000)    begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
        total++; if (rdata !== 16'h0)   begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_strobe got=%b%b exp=00", mem_en, mem_we); end
        total++; if (mem_addr !== 8'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL reset_mem_bus got=%h/%h exp=00/0000", mem_addr, mem_wdata); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_contention();
        logic [2:0]  g_exp [4];
        logic [2:0]  rv_exp [4];
        logic [15:0] rd_exp [4];
        g_exp  = '{3'b001, 3'b010, 3'b100, 3'b001};
        rv_exp = '{3'b000, 3'b001, 3'b010, 3'b100};
        rd_exp = '{16'h0000, 16'hBEEF, 16'hCAFE, 16'hF00D};
        @(negedge clock);
        req = 3'b111; we = 3'b000; addr = {8'h30, 8'h20, 8'h10};
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            total++; if (gnt !== g_exp[i]) begin bad++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, gnt, g_exp[i]); end
            total++; if (rvalid !== rv_exp[i] || rdata !== rd_exp[i]) begin bad++; $display("FAIL contention_read[%0d] got=%b/%h exp=%b/%h", i, rvalid, rdata, rv_exp[i], rd_exp[i]); end
        end
        @(posedge clock); #1;
        req = 3'b000;
        total++; if (rvalid !== 3'b001 || rdata !== 16'hBEEF) begin bad++; $display("FAIL contention_last got=%b/%h exp=001/beef", rvalid, rdata); end
    endtask

    task automatic test_single_read();
        @(negedge clock);
        req = 3'b001; we = 3'b000; addr[7:0] = 8'h10;
        #1;
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL read_gnt got=%b exp=001", gnt); end
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin bad++; $display("FAIL read_cmd got=%b%b/%h exp=10/10", mem_en, mem_we, mem_addr); end
        @(posedge clock); #1;
        req = 3'b000;
        total++; if (rvalid !== 3'b001 || rdata !== 16'hBEEF) begin bad++; $display("FAIL read_data got=%b/%h exp=001/beef", rvalid, rdata); end
        @(posedge clock); #1;
        total++; if (rvalid !== 3'b000 || rdata !== 16'h0) begin bad++; $display("FAIL read_idle got=%b/%h exp=000/0000", rvalid, rdata); end
    endtask

    task automatic test_write();
        @(negedge clock);
        req = 3'b100; we = 3'b100; addr[23:16] = 8'h3F; wdata[47:32] = 16'h1234;
        #1;
        total++; if (gnt !== 3'b100) begin bad++; $display("FAIL write_gnt got=%b exp=100", gnt); end
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h3F || mem_wdata !== 16'h1234) begin bad++; $display("FAIL write_cmd got=%b%b/%h/%h exp=11/3f/1234", mem_en, mem_we, mem_addr, mem_wdata); end
        @(posedge clock); #1;
        req = 3'b000; we = 3'b000;
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL write_rvalid got=%b exp=000", rvalid); end
        @(negedge clock);
        req = 3'b001; addr[7:0] = 8'h3F;
        @(posedge clock); #1;
        req = 3'b000;
        total++; if (rvalid !== 3'b001 || rdata !== 16'h1234) begin bad++; $display("FAIL write_readback got=%b/%h exp=001/1234", rvalid, rdata); end
    endtask

    task automatic test_idle();
        @(negedge clock);
        req = 3'b000; we = 3'b111; addr = {8'h30, 8'h20, 8'h10}; wdata = {16'h3333, 16'h2222, 16'h1111};
        #1;
        total++; if (gnt !== 3'b000 || mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL idle_strobe got=%b/%b%b exp=000/00", gnt, mem_en, mem_we); end
        total++; if (mem_addr !== 8'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL idle_bus got=%h/%h exp=00/0000", mem_addr, mem_wdata); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        we = 3'b000; req = 3'b111;
        #1;
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL idle_ptr_hold got=%b exp=010", gnt); end
        req = 3'b000;
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        req = 3'b010; addr[15:8] = 8'h20;
        #1;
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL b2b_first got=%b exp=010", gnt); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            total++; if (gnt !== 3'b010 || rvalid !== 3'b010 || rdata !== 16'hCAFE) begin bad++; $display("FAIL b2b[%0d] got=%b/%b/%h exp=010/010/cafe", i, gnt, rvalid, rdata); end
        end
        req = 3'b000;
        @(posedge clock);
    endtask

    task automatic test_lock();
        @(negedge clock);
        req = 3'b111; we = 3'b000; addr = {8'h30, 8'h20, 8'h10}; lock_req = 1'b1;
        #1;
        total++; if (gnt !== 3'b100 || locked !== 1'b0) begin bad++; $display("FAIL lock_entry_cycle got=%b/%b exp=100/0", gnt, locked); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            total++; if (locked !== 1'b1 || gnt !== 3'b100) begin bad++; $display("FAIL lock_hold[%0d] got=%b/%b exp=1/100", i, locked, gnt); end
            total++; if (rvalid !== 3'b100 || rdata !== 16'hF00D) begin bad++; $display("FAIL lock_read[%0d] got=%b/%h exp=100/f00d", i, rvalid, rdata); end
        end
        lock_req = 1'b0;
        #1;
        total++; if (locked !== 1'b1 || gnt !== 3'b100) begin bad++; $display("FAIL lock_exit_cycle got=%b/%b exp=1/100", locked, gnt); end
        @(posedge clock); #1;
        total++; if (locked !== 1'b0 || gnt !== 3'b001) begin bad++; $display("FAIL lock_released got=%b/%b exp=0/001", locked, gnt); end
        req = 3'b000;
        @(posedge clock);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        req = 3'b010; we = 3'b000; lock_req = 1'b1;
        #1;
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rst_pre_gnt got=%b exp=010", gnt); end
        @(posedge clock); #1;
        total++; if (locked !== 1'b1 || rvalid !== 3'b010) begin bad++; $display("FAIL rst_pre_state got=%b/%b exp=1/010", locked, rvalid); end
        req = 3'b100;
        #1;
        total++; if (gnt !== 3'b100) begin bad++; $display("FAIL rst_host_gnt got=%b exp=100", gnt); end
        #1;
        reset = 1'b0; req = 3'b000; lock_req = 1'b0;
        #1;
        total++; if (rvalid !== 3'b000 || rdata !== 16'h0 || locked !== 1'b0) begin bad++; $display("FAIL rst_async got=%b/%h/%b exp=000/0000/0", rvalid, rdata, locked); end
        @(posedge clock); #1;
        total++; if (rvalid !== 3'b000 || rdata !== 16'h0 || locked !== 1'b0) begin bad++; $display("FAIL rst_held got=%b/%h/%b exp=000/0000/0", rvalid, rdata, locked); end
        @(negedge clock);
        reset = 1'b1; req = 3'b111;
        #1;
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL rst_ptr_cleared got=%b exp=001", gnt); end
        req = 3'b000;
        @(posedge clock);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mem_rdata = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'hCAFE;
        mem[8'h30] = 16'hF00D;
        test_reset();
        test_contention();
        test_single_read();
        test_write();
        test_idle();
        test_back_to_back();
        test_lock();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
